neuron_train_sequencer5: RTL and testbench

Training/evaluation driver for a 5-output learning layer such as `neuron_learn_layer5`. It sits on the layer's input side and acts as the initiator of that interface. It holds a small sample memory of input vectors with their expected outputs, presents each sample, asserts `valid` and then `valid`+`learn`, captures the layer output, and accumulates absolute error per epoch. Host logic loads samples, starts a run, and reads per-epoch error reports.

---
 rtl/neuron_train_sequencer5.sv | 196 +++++++++++++++++++
 tb/tb_neuron_train_sequencer5.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_train_sequencer5.sv
// Training/evaluation driver for a 5-output learning layer: replays stored samples,
// issues valid/learn strobes, and accumulates per-epoch absolute error.
module neuron_train_sequencer5 #(
   parameter int N     = 16,
   parameter int DEPTH = 8,
   parameter int LAT   = 1
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         load_en,
   input  logic [$clog2(DEPTH)-1:0]     load_addr,
   input  logic [N-1:0][7:0]            load_in,
   input  logic [4:0][7:0]              load_expected,
   input  logic                         start,
   input  logic [15:0]                  epochs,
   input  logic [$clog2(DEPTH):0]       sample_count,
   input  logic                         train,
   output logic                         busy,
   output logic                         done,
   output logic [31:0]                  epoch_error,
   output logic                         epoch_error_valid,
   output logic [15:0]                  epoch_index,
   output logic                         valid,
   output logic                         learn,
   output logic [N-1:0][7:0]            in,
   output logic [4:0][7:0]              expected_out,
   input  logic [4:0][7:0]              layer_out
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_PRESENT, S_WAIT, S_CAPTURE, S_LEARN, S_NEXT
   } state_t;

   state_t               state_q;
   logic                 busy_q, done_q, eev_q, valid_q, learn_q;
   logic [31:0]          epoch_error_q, acc_q;
   logic [15:0]          epoch_index_q, epoch_q, epochs_q, wait_q;
   logic [N-1:0][7:0]    in_q;
   logic [4:0][7:0]      exp_q;
   logic [AW-1:0]        idx_q;
   logic [AW:0]          cnt_q;
   logic                 train_q;

   logic [N-1:0][7:0]    mem_in  [DEPTH];
   logic [4:0][7:0]      mem_exp [DEPTH];

   // NOTE: the sample memory has no reset on purpose; its contents must survive a
   // mid-run reset, and a reset would also block inference of a plain RAM.
   always_ff @(posedge clock) begin
      if (load_en && !busy_q) begin
         mem_in[load_addr]  <= load_in;
         mem_exp[load_addr] <= load_expected;
      end
   end

   function automatic logic [10:0] abs_sum(input logic [4:0][7:0] a, input logic [4:0][7:0] b);
      logic [8:0] d;
      abs_sum = '0;
      for (int k = 0; k < 5; k++) begin
         d = {1'b0, a[k]} - {1'b0, b[k]};
         if (d[8]) d = -d;
         abs_sum = abs_sum + {2'b00, d};
      end
   endfunction

   logic [10:0]   err_sum;
   logic [32:0]   acc_sum;
   logic [31:0]   acc_d, acc_fin;
   logic          last_sample, last_epoch, to_next;
   logic [AW-1:0] pres_idx;
   logic [AW:0]   cnt_clamped;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      err_sum     = abs_sum(layer_out, exp_q);
      acc_sum     = {1'b0, acc_q} + {22'b0, err_sum};
      acc_d       = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      acc_fin     = (state_q == S_CAPTURE) ? acc_d : acc_q;
      last_sample = ({1'b0, idx_q} == cnt_q - (AW+1)'(1));
      last_epoch  = (epoch_q == epochs_q - 16'd1);
      to_next     = ((state_q == S_CAPTURE) && !train_q) || (state_q == S_LEARN);
      cnt_clamped = (sample_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : sample_count;
      pres_idx    = '0;
      if ((state_q == S_NEXT) && !last_sample) pres_idx = idx_q + AW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         eev_q         <= 1'b0;
         valid_q       <= 1'b0;
         learn_q       <= 1'b0;
         epoch_error_q <= '0;
         epoch_index_q <= '0;
         in_q          <= '0;
         exp_q         <= '0;
         acc_q         <= '0;
         epoch_q       <= '0;
         epochs_q      <= '0;
         wait_q        <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         train_q       <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         eev_q   <= 1'b0;
         valid_q <= 1'b0;
         learn_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if ((epochs != 16'd0) && (sample_count != '0)) begin
                     state_q  <= S_PRESENT;
                     busy_q   <= 1'b1;
                     epochs_q <= epochs;
                     cnt_q    <= cnt_clamped;
                     train_q  <= train;
                     idx_q    <= '0;
                     epoch_q  <= '0;
                     acc_q    <= '0;
                     valid_q  <= 1'b1;
                     in_q     <= mem_in[0];
                     exp_q    <= mem_exp[0];
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_PRESENT: begin
               state_q <= S_WAIT;
               wait_q  <= 16'(LAT - 1);
            end
            S_WAIT: begin
               if (wait_q == 16'd0) state_q <= S_CAPTURE;
               else                 wait_q  <= wait_q - 16'd1;
            end
            S_CAPTURE: begin
               acc_q <= acc_d;
               if (train_q) begin
                  state_q <= S_LEARN;
                  valid_q <= 1'b1;
                  learn_q <= 1'b1;
               end
            end
            S_LEARN: ;
            S_NEXT: begin
               if (last_sample && last_epoch) begin
                  state_q <= S_IDLE;
               end else begin
                  if (last_sample) begin
                     epoch_q <= epoch_q + 16'd1;
                     acc_q   <= '0;
                  end
                  idx_q   <= pres_idx;
                  state_q <= S_PRESENT;
                  valid_q <= 1'b1;
                  in_q    <= mem_in[pres_idx];
                  exp_q   <= mem_exp[pres_idx];
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Epoch report and end-of-run pulses are visible during the NEXT cycle itself.
         if (to_next) begin
            state_q <= S_NEXT;
            if (last_sample) begin
               epoch_error_q <= acc_fin;
               epoch_index_q <= epoch_q;
               eev_q         <= 1'b1;
               if (last_epoch) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
         end
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign epoch_error       = epoch_error_q;
   assign epoch_error_valid = eev_q;
   assign epoch_index       = epoch_index_q;
   assign valid             = valid_q;
   assign learn             = learn_q;
   assign in                = in_q;
   assign expected_out      = exp_q;

endmodule

// File: tb/tb_neuron_train_sequencer5.sv
// Directed bench for neuron_train_sequencer5: one instance with LAT=1 (eval cases)
// and one with LAT=2 (train case), sharing the load bus and layer stub.
module tb_neuron_train_sequencer5;
   localparam int N     = 16;
   localparam int DEPTH = 8;

   typedef logic [N-1:0][7:0] vec_t;
   typedef logic [4:0][7:0]   out_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n, load_en, train, start1, start2, sel;
   logic [2:0]  load_addr;
   vec_t        load_in;
   out_t        load_expected, layer_out;
   logic [15:0] epochs;
   logic [3:0]  sample_count;

   logic        busy1, done1, eev1, valid1, learn1, busy2, done2, eev2, valid2, learn2;
   logic [31:0] err1, err2;
   logic [15:0] eidx1, eidx2;
   vec_t        in1, in2;
   out_t        exo1, exo2;

   neuron_train_sequencer5 #(.N(N), .DEPTH(DEPTH), .LAT(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
      .load_in(load_in), .load_expected(load_expected), .start(start1), .epochs(epochs),
      .sample_count(sample_count), .train(train), .busy(busy1), .done(done1),
      .epoch_error(err1), .epoch_error_valid(eev1), .epoch_index(eidx1), .valid(valid1),
      .learn(learn1), .in(in1), .expected_out(exo1), .layer_out(layer_out));

   neuron_train_sequencer5 #(.N(N), .DEPTH(DEPTH), .LAT(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
      .load_in(load_in), .load_expected(load_expected), .start(start2), .epochs(epochs),
      .sample_count(sample_count), .train(train), .busy(busy2), .done(done2),
      .epoch_error(err2), .epoch_error_valid(eev2), .epoch_index(eidx2), .valid(valid2),
      .learn(learn2), .in(in2), .expected_out(exo2), .layer_out(layer_out));

   logic        m_busy, m_done, m_eev, m_valid, m_learn;
   logic [31:0] m_err;
   logic [15:0] m_eidx;
   vec_t        m_in;
   assign m_busy  = sel ? busy2  : busy1;
   assign m_done  = sel ? done2  : done1;
   assign m_eev   = sel ? eev2   : eev1;
   assign m_valid = sel ? valid2 : valid1;
   assign m_learn = sel ? learn2 : learn1;
   assign m_err   = sel ? err2   : err1;
   assign m_eidx  = sel ? eidx2  : eidx1;
   assign m_in    = sel ? in2    : in1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic vec_t sample_vec(input int s);
      vec_t v;
      for (int k = 0; k < N; k++) v[k] = (s == 0) ? 8'(k + 1) : 8'(8'h80 + k);
      return v;
   endfunction

   // Per-run observations, indexed by cycle number after the accepted start edge.
   int   n_valid, n_learn, learn_bad, n_done, done_cyc;
   logic done_seen, busy_seen;
   int   valid_cyc[$];
   int   eev_cyc[$];
   logic [15:0] eev_idx[$];
   logic [31:0] eev_err[$];
   vec_t in_at[$];

   task automatic load(input logic [2:0] a, input vec_t v, input out_t e);
      @(negedge clock);
      load_en = 1'b1; load_addr = a; load_in = v; load_expected = e;
      @(negedge clock);
      load_en = 1'b0;
   endtask

   task automatic run(input logic which, input logic [15:0] ep, input logic [3:0] sc,
                      input logic tr, input int inject, input int stop_at);
      n_valid = 0; n_learn = 0; learn_bad = 0; n_done = 0; done_cyc = -1;
      done_seen = 1'b0; busy_seen = 1'b0;
      valid_cyc.delete(); eev_cyc.delete(); eev_idx.delete(); eev_err.delete(); in_at.delete();
      sel = which;
      @(negedge clock);
      epochs = ep; sample_count = sc; train = tr;
      if (which) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clock);
      #1 start1 = 1'b0; start2 = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clock);
         if (m_valid) begin
            n_valid++;
            valid_cyc.push_back(c);
            if (!m_learn) in_at.push_back(m_in);
         end
         if (m_learn) begin
            n_learn++;
            if (!m_valid) learn_bad++;
         end
         if (m_eev) begin
            eev_cyc.push_back(c); eev_idx.push_back(m_eidx); eev_err.push_back(m_err);
         end
         if (m_done) begin n_done++; done_cyc = c; done_seen = 1'b1; end
         if (m_busy) busy_seen = 1'b1;
         if (c == inject) begin
            load_en = 1'b1; load_addr = 3'd0; load_in = {N{8'h11}}; load_expected = '0;
            if (which) start2 = 1'b1; else start1 = 1'b1;
         end else begin
            load_en = 1'b0; start1 = 1'b0; start2 = 1'b0;
         end
         if (c == stop_at || done_seen) break;
      end
      load_en = 1'b0; start1 = 1'b0; start2 = 1'b0;
      if (stop_at == 0) check("run_finished", done_seen, 1'b1);
   endtask

   task automatic check_eval_run(input string tag);
      check({tag, "_valid_count"}, n_valid, 2);
      check({tag, "_valid_c1"}, valid_cyc[0], 1);
      check({tag, "_valid_c5"}, valid_cyc[1], 5);
      check({tag, "_no_learn"}, n_learn, 0);
      check({tag, "_eev_count"}, eev_cyc.size(), 1);
      check({tag, "_eev_cycle"}, eev_cyc[0], 8);
      check({tag, "_epoch_error"}, eev_err[0], 32'h140);
      check({tag, "_epoch_index"}, eev_idx[0], 0);
      check({tag, "_done_cycle"}, done_cyc, 8);
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_in_s0"}, in_at[0], sample_vec(0));
      check({tag, "_in_s1"}, in_at[1], sample_vec(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic late_done;
      sel = 1'b0; load_en = 1'b0; load_addr = '0; load_in = '0; load_expected = '0;
      epochs = 16'd1; sample_count = 4'd2; train = 1'b0;
      layer_out = {5{8'h60}};

      // Reset held 3 cycles with start asserted.
      reset_n = 1'b0; start1 = 1'b1; start2 = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_valid", valid1, 0);
      check("rst_learn", learn1, 0);
      check("rst_epoch_error", err1, 0);
      check("rst_eev", eev1, 0);
      check("rst_epoch_index", eidx1, 0);
      check("rst_in", in1, 0);
      check("rst_expected_out", exo1, 0);
      check("rst_dut2_busy_valid", {busy2, valid2}, 0);
      start1 = 1'b0; start2 = 1'b0; reset_n = 1'b1;

      load(3'd0, sample_vec(0), {5{8'h40}});
      load(3'd1, sample_vec(1), {5{8'h40}});

      // Eval run, LAT=1.
      run(1'b0, 16'd1, 4'd2, 1'b0, 0, 0);
      check_eval_run("eval");
      @(negedge clock);
      check("eval_busy_after", busy1, 0);

      // Train run, LAT=2, 3 epochs.
      run(1'b1, 16'd3, 4'd2, 1'b1, 0, 0);
      check("train_learn_count", n_learn, 6);
      check("train_learn_without_valid", learn_bad, 0);
      check("train_valid_count", n_valid, 12);
      check("train_eev_count", eev_cyc.size(), 3);
      check("train_eev_first", eev_cyc[0], 12);
      check("train_eev_gap1", eev_cyc[1] - eev_cyc[0], 12);
      check("train_eev_gap2", eev_cyc[2] - eev_cyc[1], 12);
      check("train_idx0", eev_idx[0], 0);
      check("train_idx1", eev_idx[1], 1);
      check("train_idx2", eev_idx[2], 2);
      check("train_err_last", eev_err[2], 32'h140);
      check("train_done_count", n_done, 1);
      check("train_done_with_eev", done_cyc, eev_cyc[2]);

      // Degenerate starts.
      run(1'b0, 16'd0, 4'd2, 1'b0, 0, 0);
      check("deg_ep_done_cycle", done_cyc, 1);
      check("deg_ep_busy", busy_seen, 0);
      check("deg_ep_valid", n_valid, 0);
      run(1'b0, 16'd1, 4'd0, 1'b0, 0, 0);
      check("deg_sc_done_cycle", done_cyc, 1);
      check("deg_sc_busy", busy_seen, 0);
      check("deg_sc_valid", n_valid, 0);

      // Load and start while busy are ignored.
      run(1'b0, 16'd1, 4'd2, 1'b0, 2, 0);
      check_eval_run("lock");
      run(1'b0, 16'd1, 4'd2, 1'b0, 0, 0);
      check("lock_mem0_kept", in_at[0], sample_vec(0));
      check("lock_err_kept", eev_err[0], 32'h140);

      // Reset during WAIT of sample 1.
      run(1'b0, 16'd1, 4'd2, 1'b0, 0, 6);
      reset_n = 1'b0;
      @(negedge clock);
      check("midrst_outputs",
            {busy1, done1, eev1, valid1, learn1, err1, eidx1}, 0);
      check("midrst_in", in1, 0);
      check("midrst_expected_out", exo1, 0);
      reset_n = 1'b1;
      late_done = 1'b0;
      repeat (4) begin
         @(negedge clock);
         late_done = late_done | done1 | eev1;
      end
      check("midrst_no_done", late_done, 0);
      run(1'b0, 16'd1, 4'd2, 1'b0, 0, 0);
      check_eval_run("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
